// File: rtl/periph_pkg.sv
// Shared CLINT register map, reset constants and register-decode helpers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package periph_pkg;

    localparam logic [15:0] OFF_MSIP        = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFF_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI    = 16'hBFFC;

    // All-ones keeps the timer interrupt quiet until software programs a compare value.
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        REG_MSIP,
        REG_CMP_LO,
        REG_CMP_HI,
        REG_TIME_LO,
        REG_TIME_HI,
        REG_NONE
    } reg_sel_e;

    // Exact match only: misaligned and unmapped offsets both fall out as REG_NONE.
    function automatic reg_sel_e decode_offset(input logic [15:0] off);
        case (off)
            OFF_MSIP:        return REG_MSIP;
            OFF_MTIMECMP_LO: return REG_CMP_LO;
            OFF_MTIMECMP_HI: return REG_CMP_HI;
            OFF_MTIME_LO:    return REG_TIME_LO;
            OFF_MTIME_HI:    return REG_TIME_HI;
            default:         return REG_NONE;
        endcase
    endfunction

    function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/apb_clint_if.sv
// APB3/4 bus bundle between a requester and the CLINT register slave.
// Latency: none (wires only).
// Backpressure: slave stalls the requester by holding pready low.
interface apb_clint_if;
    logic        psel;
    logic        penable;
    logic        pready;
    logic [33:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pwstrb,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pwstrb,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_slave_if.sv
// APB handshake: wait-state counter, pready generation and the access strobe.
// Latency: pready rises WAIT_STATES access cycles after the setup phase.
// Backpressure: holds pready low for WAIT_STATES cycles; dropping psel abandons the transfer.
// Ports: clk_i/rst_i; psel_i/penable_i/paddr_i/pwrite_i from the bus; pready_o to the bus;
//        acc_o (one-cycle commit strobe), addr_o (decoded offset), wr_o (write flag) to the registers.
module apb_slave_if #(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [15:0] paddr_i,
    input  logic        pwrite_i,
    output logic        pready_o,
    output logic        acc_o,
    output logic [15:0] addr_o,
    output logic        wr_o
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_STATES);

    logic [2:0] wait_q, wait_d;
    logic       rdy_q, rdy_d;

    always_comb begin
        wait_d = wait_q;
        rdy_d  = rdy_q;
        if (!psel_i) begin
            // Idle or abandoned transfer: forget any partial wait count.
            wait_d = 3'd0;
            rdy_d  = 1'b0;
        end else if (!penable_i) begin
            wait_d = WAIT_LOAD;
            rdy_d  = (WAIT_LOAD == 3'd0);
        end else if (rdy_q) begin
            // Completion cycle; ready is a single-cycle pulse.
            wait_d = 3'd0;
            rdy_d  = 1'b0;
        end else begin
            // Guard against underflow if penable arrives without a setup phase.
            wait_d = (wait_q == 3'd0) ? 3'd0 : wait_q - 3'd1;
            rdy_d  = (wait_q <= 3'd1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_q <= 3'd0;
            rdy_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            rdy_q  <= rdy_d;
        end
    end

    assign pready_o = rdy_q & psel_i;
    assign acc_o    = rdy_q & psel_i & penable_i;
    assign addr_o   = paddr_i;
    assign wr_o     = pwrite_i;

endmodule

// File: rtl/apb_clint.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp and MSIP behind an APB slave.
// Latency: WAIT_STATES access cycles per transfer; mtimer_int lags mtime/mtimecmp by one cycle.
// Backpressure: APB pready low for WAIT_STATES cycles; bad offsets complete with pslverr.
// Ports: clk, rst (sync, active-high); bus (APB slave modport); mtime, mtimer_int, msip_int.
module apb_clint
    import periph_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned TICK_DIV    = 1
) (
    input  logic        clk,
    input  logic        rst,
    apb_clint_if.slave  bus,
    output logic [63:0] mtime,
    output logic        mtimer_int,
    output logic        msip_int
);

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    logic        pready, acc, acc_wr;
    logic [15:0] acc_addr;

    apb_slave_if #(.WAIT_STATES(WAIT_STATES)) u_apb_slave (
        .clk_i     (clk),
        .rst_i     (rst),
        .psel_i    (bus.psel),
        .penable_i (bus.penable),
        .paddr_i   (bus.paddr[15:0]),
        .pwrite_i  (bus.pwrite),
        .pready_o  (pready),
        .acc_o     (acc),
        .addr_o    (acc_addr),
        .wr_o      (acc_wr)
    );

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        int_q;
    logic        tick;
    reg_sel_e    sel;
    logic        bad_off, wr_en;
    logic [31:0] rdata;

    assign sel     = decode_offset(acc_addr);
    assign bad_off = (sel == REG_NONE);
    assign wr_en   = acc & acc_wr & ~bad_off;
    assign tick    = (presc_q == PRESC_MAX);
    assign presc_d = tick ? 16'd0 : presc_q + 16'd1;

    always_comb begin
        rdata = 32'd0;
        case (sel)
            REG_MSIP:    rdata = {31'd0, msip_q};
            REG_CMP_LO:  rdata = mtimecmp_q[31:0];
            REG_CMP_HI:  rdata = mtimecmp_q[63:32];
            REG_TIME_LO: rdata = mtime_q[31:0];
            REG_TIME_HI: rdata = mtime_q[63:32];
            default:     rdata = 32'd0;
        endcase
    end

    // A software write to either half replaces the whole update, so the tick and
    // any carry into the other half are dropped on that cycle.
    always_comb begin
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_en && sel == REG_TIME_LO)
            mtime_d = {mtime_q[63:32], merge_strb(mtime_q[31:0], bus.pwdata, bus.pwstrb)};
        else if (wr_en && sel == REG_TIME_HI)
            mtime_d = {merge_strb(mtime_q[63:32], bus.pwdata, bus.pwstrb), mtime_q[31:0]};
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_en && sel == REG_CMP_LO)
            mtimecmp_d[31:0]  = merge_strb(mtimecmp_q[31:0], bus.pwdata, bus.pwstrb);
        else if (wr_en && sel == REG_CMP_HI)
            mtimecmp_d[63:32] = merge_strb(mtimecmp_q[63:32], bus.pwdata, bus.pwstrb);
    end

    always_comb begin
        msip_d = msip_q;
        if (wr_en && sel == REG_MSIP && bus.pwstrb[0])
            msip_d = bus.pwdata[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= 16'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= MTIMECMP_RST;
            msip_q     <= 1'b0;
            int_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            int_q      <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.pready  = pready;
    assign bus.prdata  = (pready && !acc_wr && !bad_off) ? rdata : 32'd0;
    assign bus.pslverr = pready & bad_off;

    assign mtime      = mtime_q;
    assign mtimer_int = int_q;
    assign msip_int   = msip_q;

endmodule

// File: tb/tb_apb_clint.sv
// Randomized and directed bench for apb_clint against a register-level reference model.
// Latency: checks every cycle on the falling edge.
// Backpressure: waits on pready with a bounded cycle budget.
module tb_apb_clint;

    localparam int WS = 1;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] mtime;
    logic        mtimer_int, msip_int;

    always #5 clk = ~clk;

    apb_clint_if bus ();

    apb_clint #(.WAIT_STATES(WS), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .mtime      (mtime),
        .mtimer_int (mtimer_int),
        .msip_int   (msip_int)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: architectural register contents plus cycles elapsed since reset.
    logic [63:0] m_time, m_cmp;
    logic        m_msip, m_int;
    int unsigned m_cyc;
    logic        c_vld = 1'b0;
    logic [15:0] c_off;
    logic [31:0] c_data;
    logic [3:0]  c_strb;

    function automatic logic [31:0] bytes_merge(input logic [31:0] o, input logic [31:0] d,
                                                input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic model_read(input logic [15:0] off, output logic [31:0] d, output logic e);
        e = 1'b0;
        case (off)
            16'h0000: d = {31'd0, m_msip};
            16'h4000: d = m_cmp[31:0];
            16'h4004: d = m_cmp[63:32];
            16'hBFF8: d = m_time[31:0];
            16'hBFFC: d = m_time[63:32];
            default: begin d = 32'd0; e = 1'b1; end
        endcase
    endtask

    task automatic model_edge();
        logic nxt_int, tick, tw;
        if (rst) begin
            m_time = 64'd0;
            m_cmp  = 64'hFFFF_FFFF_FFFF_FFFF;
            m_msip = 1'b0;
            m_int  = 1'b0;
            m_cyc  = 0;
        end else begin
            nxt_int = (m_time >= m_cmp);
            tick    = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            tw = c_vld && (c_off == 16'hBFF8 || c_off == 16'hBFFC);
            if (tw) begin
                if (c_off == 16'hBFF8) m_time[31:0]  = bytes_merge(m_time[31:0], c_data, c_strb);
                else                   m_time[63:32] = bytes_merge(m_time[63:32], c_data, c_strb);
            end else if (tick) begin
                m_time = m_time + 64'd1;
            end
            if (c_vld && c_off == 16'h4000) m_cmp[31:0]  = bytes_merge(m_cmp[31:0], c_data, c_strb);
            if (c_vld && c_off == 16'h4004) m_cmp[63:32] = bytes_merge(m_cmp[63:32], c_data, c_strb);
            if (c_vld && c_off == 16'h0000 && c_strb[0]) m_msip = c_data[0];
            m_int = nxt_int;
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mtime", mtime, m_time);
        check("mtimer_int", mtimer_int, m_int);
        check("msip_int", msip_int, m_msip);
        if (!bus.psel) begin
            check("idle_pready", bus.pready, 1'b0);
            check("idle_prdata", bus.prdata, 32'd0);
            check("idle_pslverr", bus.pslverr, 1'b0);
        end
    endtask

    task automatic xfer(input logic [15:0] off, input logic wr, input logic [31:0] wd,
                        input logic [3:0] st, input bit abandon);
        logic [31:0] ed;
        logic        ee;
        logic [17:0] upper;
        int          waits;
        upper        = 18'($urandom);
        bus.psel     = 1'b1;
        bus.penable  = 1'b0;
        bus.paddr    = {upper, off};
        bus.pwrite   = wr;
        bus.pwdata   = wd;
        bus.pwstrb   = st;
        cyc();
        bus.penable  = 1'b1;
        #1;
        if (abandon) begin
            check("abandon_pready", bus.pready, 1'b0);
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            cyc();
            return;
        end
        waits = 0;
        while (!bus.pready && waits < 16) begin
            check("wait_prdata", bus.prdata, 32'd0);
            cyc();
            waits++;
        end
        check("wait_states", waits, WS);
        if (!bus.pready) begin
            bus.psel    = 1'b0;
            bus.penable = 1'b0;
            cyc();
            return;
        end
        model_read(off, ed, ee);
        if (wr) ed = 32'd0;
        check("prdata", bus.prdata, ed);
        check("pslverr", bus.pslverr, ee);
        if (wr && !ee) begin
            c_vld  = 1'b1;
            c_off  = off;
            c_data = wd;
            c_strb = st;
        end
        cyc();
        c_vld       = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [15:0] offs[10];
        logic [63:0] saved_cmp;
        logic        saved_msip;
        int          n;
        offs = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC,
                 16'h0008, 16'h4002, 16'hBFFA, 16'h0000, 16'h0004};

        bus.psel = 1'b0; bus.penable = 1'b0; bus.paddr = '0;
        bus.pwrite = 1'b0; bus.pwdata = '0; bus.pwstrb = '0;
        rst = 1'b1;
        repeat (3) cyc();
        check("rst_pready", bus.pready, 1'b0);
        check("rst_prdata", bus.prdata, 32'd0);
        check("rst_pslverr", bus.pslverr, 1'b0);
        check("rst_mtime", mtime, 64'd0);
        check("rst_mtimer_int", mtimer_int, 1'b0);
        check("rst_msip_int", msip_int, 1'b0);

        // First transfer right after reset release: compare-hi reads all ones.
        rst = 1'b0;
        xfer(16'h4004, 1'b0, 32'd0, 4'h0, 1'b0);

        // Compare = 5, hi first; interrupt rises one cycle after mtime reaches 5.
        xfer(16'h4004, 1'b1, 32'd0, 4'hF, 1'b0);
        xfer(16'h4000, 1'b1, 32'd5, 4'hF, 1'b0);
        n = 0;
        while (!mtimer_int && n < 100) begin cyc(); n++; end
        check("cmp_rise_seen", mtimer_int, 1'b1);
        check("cmp_rise_mtime", mtime, 64'd5);
        xfer(16'h4004, 1'b1, 32'd1, 4'hF, 1'b0);
        cyc();
        check("cmp_fall", mtimer_int, 1'b0);

        // MSIP honours only byte-lane 0.
        xfer(16'h0000, 1'b1, 32'd1, 4'b0010, 1'b0);
        check("msip_lane1", msip_int, 1'b0);
        xfer(16'h0000, 1'b1, 32'd1, 4'b0001, 1'b0);
        check("msip_lane0", msip_int, 1'b1);

        // Bad offsets: error, zero data, no state change.
        saved_cmp  = m_cmp;
        saved_msip = m_msip;
        xfer(16'h0008, 1'b0, 32'd0, 4'h0, 1'b0);
        xfer(16'h4002, 1'b0, 32'd0, 4'h0, 1'b0);
        xfer(16'h0008, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        xfer(16'h4002, 1'b1, 32'h0, 4'hF, 1'b0);
        check("badoff_cmp", m_cmp, saved_cmp);
        check("badoff_msip", msip_int, saved_msip);
        xfer(16'h4000, 1'b0, 32'd0, 4'h0, 1'b0);
        xfer(16'h0000, 1'b0, 32'd0, 4'h0, 1'b0);

        // Carry across the 32-bit boundary.
        xfer(16'hBFF8, 1'b1, 32'hFFFF_FFFE, 4'hF, 1'b0);
        xfer(16'hBFFC, 1'b1, 32'h0, 4'hF, 1'b0);
        n = 0;
        while (mtime != 64'h1_0000_0000 && n < 16) begin cyc(); n++; end
        check("carry_reach", mtime, 64'h1_0000_0000);

        // Full 64-bit wrap.
        xfer(16'hBFFC, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        xfer(16'hBFF8, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0);
        repeat (8) cyc();
        check("wrap_small", mtime < 64'd4, 1'b1);

        // Abandoned write must not commit and must not skew the next transfer.
        xfer(16'h4000, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b1);
        xfer(16'h4000, 1'b0, 32'd0, 4'h0, 1'b0);

        for (int i = 0; i < 250; i++) begin
            logic [15:0] off;
            off = offs[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) off = 16'($urandom);
            xfer(off, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) cyc();
        end

        // Reset in the completion cycle of an mtime write: write lost, pready drops.
        bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = 34'h0_0000_BFF8;
        bus.pwrite = 1'b1; bus.pwdata = 32'h1234; bus.pwstrb = 4'hF;
        cyc();
        bus.penable = 1'b1;
        n = 0;
        while (!bus.pready && n < 16) begin cyc(); n++; end
        check("rstx_ready_seen", bus.pready, 1'b1);
        rst = 1'b1;
        cyc();
        check("rstx_pready", bus.pready, 1'b0);
        check("rstx_mtime", mtime, 64'd0);
        rst = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        cyc();
        xfer(16'hBFF8, 1'b0, 32'd0, 4'h0, 1'b0);
        check("rstx_lost", (mtime[31:0] < 32'h1234), 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_clint.md
APB_CLINT -- requirements
Module: apb_clint

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1: the number of access-phase cycles with pready low before pready rises (0..7).
REQ-002 The block SHALL have parameter TICK_DIV, default 1: the number of clk cycles per mtime increment (1..65535).
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 psel  input  1  APB select.
REQ-006 penable  input  1  APB access phase.
REQ-007 pready  output  1  APB transfer complete.
REQ-008 paddr  input  34  APB byte address; only paddr[15:0] is decoded.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 pwdata  input  32  write data.
REQ-011 pwstrb  input  4  byte write strobes.
REQ-012 prdata  output  32  read data, valid while pready=1.
REQ-013 pslverr  output  1  error response, valid while pready=1.
REQ-014 mtime  output  64  current timer value.
REQ-015 mtimer_int  output  1  machine timer interrupt.
REQ-016 msip_int  output  1  machine software interrupt.

Function
REQ-017 Register map (offset = paddr[15:0]): 0x0000 MSIP (bit0 only, other bits read 0); 0x4000 MTIMECMP[31:0]; 0x4004 MTIMECMP[63:32]; 0xBFF8 MTIME[31:0]; 0xBFFC MTIME[63:32].
REQ-018 Setup phase is psel=1 with penable=0; access phase is psel=1 with penable=1.
REQ-019 A wait counter SHALL load at the setup phase; pready SHALL be 0 for exactly WAIT_STATES access-phase cycles and then 1 for exactly one cycle.
REQ-020 A transfer completes on the cycle with psel=1, penable=1 and pready=1; writes commit at that edge.
REQ-021 pready SHALL be 0 whenever psel=0.
REQ-022 A write SHALL update only the bytes whose pwstrb bit is 1; pwstrb=0 SHALL be a no-op with no error.
REQ-023 An offset that is unmapped or not word-aligned SHALL complete with pslverr=1 and prdata=0; a write to it SHALL change no state.
REQ-024 prdata SHALL be 0 on every cycle with pready=0, and on writes.
REQ-025 A prescaler SHALL count 0..TICK_DIV-1; mtime SHALL increment by 1 (mod 2^64) on the cycle the prescaler wraps.
REQ-026 A committed write to MTIME SHALL take priority over a same-cycle increment; the increment is dropped.
REQ-027 A write to one half of MTIME SHALL leave the other half unchanged, with no carry between halves on that cycle.
REQ-028 mtime SHALL wrap from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-029 mtimer_int SHALL be registered as (mtime >= mtimecmp), unsigned 64-bit compare, one cycle after mtime or mtimecmp changes.
REQ-030 msip_int SHALL equal MSIP bit0 as a register output.
REQ-031 A read of MTIME SHALL return the value held before that cycle's increment.
REQ-032 If psel drops mid-transfer, the transfer SHALL be abandoned with no state change, and the wait counter SHALL clear.

Reset
REQ-033 While rst=1 at a clk edge: mtime=0, prescaler=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, MSIP=0, pready=0, prdata=0, pslverr=0, mtimer_int=0, msip_int=0.
REQ-034 Reset asserted during a transfer SHALL abort it: no write commit, and pready=0 on the following cycle.
REQ-035 The first transfer SHALL be accepted in the cycle after rst deasserts.

Structure
REQ-036 Register offsets and the mtimecmp reset constant SHALL live in shared package periph_pkg; parameters stay local to the module.
REQ-037 APB handshake and wait-state logic SHALL be one sub-module, apb_slave_if, exporting a one-cycle access strobe, the address, and the write/read flag to the register logic.

Verification
REQ-038 WAIT_STATES=1: read MTIMECMP hi after reset -> pready high on the 2nd access cycle, prdata=0xFFFFFFFF, pslverr=0.
REQ-039 TICK_DIV=4: write MTIME lo=0xFFFFFFFE, hi=0 -> mtime reaches 0x1_0000_0000 after 8 clk cycles.
REQ-040 Write MTIMECMP=5 (hi first, then lo), with mtime counting from 0 -> mtimer_int rises one cycle after mtime=5; then write MTIMECMP hi=1 -> mtimer_int falls.
REQ-041 Write MSIP 0x1 with pwstrb=4'b0010 -> msip_int stays 0; repeat with pwstrb=4'b0001 -> msip_int=1.
REQ-042 Access offset 0x0008 and offset 0x4002 -> pslverr=1, prdata=0, no register changes.
REQ-043 Assert rst in the access phase of a write to MTIME lo=0x1234 -> mtime=0, pready=0, and the write is lost.
